// File: rtl/parallel_bus_pkg.sv
// parallel_bus_pkg: FSM states, default widths and pwd mode constants shared by the parallel bus master and slave.
package parallel_bus_pkg;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_REGS    = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam logic PWD_8BIT      = 1'b0;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_HOLD = 2'd1,
    ST_RD_HOLD = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_e;
endpackage

// File: rtl/parallel_slave_regs_strobe_sync.sv
// strobe_sync: multi-stage synchronizer for an active-low bus strobe; it resets to the idle level (1).
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ff <= '1;
    else      r_ff <= {r_ff[STAGES-2:0], i_d};
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/parallel_slave_regs.sv
// parallel_slave_regs: responder for the 8-bit parallel register bus, backed by a register file.
// Define PARALLEL_SLV_ERR_EN to build the sticky err detector; otherwise err is tied 0.
module parallel_slave_regs
  import parallel_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic                         rd,
  input  logic                         pwd,
  input  logic [ADDR_WIDTH-1:0]        p_addr,
  input  logic [DATA_WIDTH-1:0]        p_wdata,
  output logic [DATA_WIDTH-1:0]        p_rdata,
  output logic                         data_tri_select,
  output logic                         reg_wr_evt,
  output logic [ADDR_WIDTH-1:0]        reg_wr_addr,
  output logic [DATA_WIDTH-1:0]        reg_wr_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                         err
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  logic                  w_wr_s, w_rd_s;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_tri, r_evt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  bus_state_e            r_state, w_next;
  logic                  w_wr_go, w_rd_go, w_rd_done, w_in_range;
  logic [IW-1:0]         w_idx;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (.clk(clk), .rst(rst), .i_d(wr), .o_q(w_wr_s));
  strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (.clk(clk), .rst(rst), .i_d(rd), .o_q(w_rd_s));

  // addr/wdata are only consumed after the synced strobe goes low, so one register stage is enough
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else begin
      r_addr_q  <= p_addr;
      r_wdata_q <= p_wdata;
    end

  assign w_in_range = {1'b0, r_addr_q} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign w_idx      = r_addr_q[IW-1:0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    w_wr_go   = 1'b0;
    w_rd_go   = 1'b0;
    w_rd_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_wr_go = !w_wr_s;
        w_rd_go = w_wr_s && !w_rd_s;
        w_next  = w_wr_go ? ST_WR_HOLD : (w_rd_go ? ST_RD_HOLD : ST_IDLE);
      end
      ST_WR_HOLD: w_next = w_wr_s ? ST_RELEASE : ST_WR_HOLD;
      ST_RD_HOLD: begin
        w_rd_done = w_rd_s;
        w_next    = w_rd_s ? ST_RELEASE : ST_RD_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (w_wr_go && w_in_range) begin
      r_regs[w_idx] <= r_wdata_q;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rdata   <= '0;
      r_tri     <= 1'b0;
      r_evt     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_evt <= w_wr_go && w_in_range;
      if (w_wr_go && w_in_range) begin
        r_wr_addr <= r_addr_q;
        r_wr_data <= r_wdata_q;
      end
      if (w_rd_go) begin
        r_rdata <= w_in_range ? r_regs[w_idx] : '0;
        r_tri   <= 1'b1;
      end else if (w_rd_done) begin
        r_tri <= 1'b0;
      end
    end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end

  assign p_rdata         = r_rdata;
  assign data_tri_select = r_tri;
  assign reg_wr_evt      = r_evt;
  assign reg_wr_addr     = r_wr_addr;
  assign reg_wr_data     = r_wr_data;

`ifdef PARALLEL_SLV_ERR_EN
  logic r_pwd_q, r_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pwd_q <= PWD_8BIT;
      r_err   <= 1'b0;
    end else begin
      r_pwd_q <= pwd;
      if ((!w_wr_s && !w_rd_s) ||
          ((w_wr_go || w_rd_go) && (!w_in_range || r_pwd_q != PWD_8BIT)))
        r_err <= 1'b1;
    end
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = pwd ^ PWD_8BIT;
  assign err      = 1'b0;
`endif
endmodule
